// File: rtl/vedic_mul_arbiter.sv
// Round-robin arbiter sharing one Urdhva-Tiryagbhyam 8x8 multiplier among NUM_REQ requesters.
// Optional `MUL_SELFCHECK_EN adds a sticky comparator against behavioural a*b on chk_err_o.

module vedic2x2 (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] p_o
);
  logic cross0, cross1, carry1, high;

  assign cross0 = a_i[1] & b_i[0];
  assign cross1 = a_i[0] & b_i[1];
  assign carry1 = cross0 & cross1;
  assign high   = a_i[1] & b_i[1];

  assign p_o[0] = a_i[0] & b_i[0];
  assign p_o[1] = cross0 ^ cross1;
  assign p_o[2] = high ^ carry1;
  assign p_o[3] = high & carry1;
endmodule

module vedic4x4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  logic [3:0] q0, q1, q2, q3;
  logic [4:0] mid;

  vedic2x2 u0 (.a_i(a_i[1:0]), .b_i(b_i[1:0]), .p_o(q0));
  vedic2x2 u1 (.a_i(a_i[3:2]), .b_i(b_i[1:0]), .p_o(q1));
  vedic2x2 u2 (.a_i(a_i[1:0]), .b_i(b_i[3:2]), .p_o(q2));
  vedic2x2 u3 (.a_i(a_i[3:2]), .b_i(b_i[3:2]), .p_o(q3));

  assign mid = {1'b0, q1} + {1'b0, q2};
  assign p_o = {4'b0000, q0} + {1'b0, mid, 2'b00} + {q3, 4'b0000};
endmodule

module vedic8x8 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);
  logic [7:0] q0, q1, q2, q3;
  logic [8:0] mid;

  vedic4x4 u0 (.a_i(a_i[3:0]), .b_i(b_i[3:0]), .p_o(q0));
  vedic4x4 u1 (.a_i(a_i[7:4]), .b_i(b_i[3:0]), .p_o(q1));
  vedic4x4 u2 (.a_i(a_i[3:0]), .b_i(b_i[7:4]), .p_o(q2));
  vedic4x4 u3 (.a_i(a_i[7:4]), .b_i(b_i[7:4]), .p_o(q3));

  assign mid = {1'b0, q1} + {1'b0, q2};
  assign p_o = {8'h00, q0} + {3'b000, mid, 4'b0000} + {q3, 8'h00};
endmodule

module vedic_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_a_i,
  input  logic [8*NUM_REQ-1:0] req_b_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 rsp_valid_o,
  output logic [15:0]          rsp_prod_o,
  output logic [ID_W-1:0]      rsp_id_o,
  input  logic                 rsp_ready_i,
  output logic                 chk_err_o
);
  typedef enum logic {IDLE, FULL} state_e;

  localparam logic [ID_W:0] NumReqW = (ID_W+1)'(NUM_REQ);

  state_e          state_q, state_d;
  logic [ID_W-1:0] rrPtr_q, rrPtr_d;
  logic [ID_W-1:0] rspId_q, rspId_d;
  logic [7:0]      opA_q, opA_d;
  logic [7:0]      opB_q, opB_d;

  logic               free;
  logic               grantAny;
  logic [ID_W-1:0]    grantIdx;
  logic [NUM_REQ-1:0] grantOh;
  logic [7:0]         selA, selB;
  logic [15:0]        vedicProd;

  // The buffered operands are the response: the product stays valid while they are held.
  vedic8x8 uMul (.a_i(opA_q), .b_i(opB_q), .p_o(vedicProd));

  assign free = !rst && ((state_q == IDLE) || ((state_q == FULL) && rsp_ready_i));

  // First valid requester at or after rrPtr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [ID_W:0] cand;
    logic          hit;
    grantAny = 1'b0;
    grantIdx = '0;
    cand     = '0;
    hit      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rrPtr_q} + (ID_W+1)'(k);
      if (cand >= NumReqW) cand = cand - NumReqW;
      hit = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (cand == (ID_W+1)'(j)) hit = req_valid_i[j];
      end
      if (free && hit && !grantAny) begin
        grantAny = 1'b1;
        grantIdx = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    grantOh = '0;
    selA    = '0;
    selB    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantAny && (grantIdx == ID_W'(i))) begin
        grantOh[i] = 1'b1;
        selA       = req_a_i[8*i +: 8];
        selB       = req_b_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    logic [ID_W:0] nxtPtr;
    state_d = state_q;
    rrPtr_d = rrPtr_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    rspId_d = rspId_q;
    nxtPtr  = '0;
    case (state_q)
      IDLE: if (grantAny) state_d = FULL;
      FULL: if (rsp_ready_i && !grantAny) state_d = IDLE;
    endcase
    if (grantAny) begin
      opA_d   = selA;
      opB_d   = selB;
      rspId_d = grantIdx;
      nxtPtr  = {1'b0, grantIdx} + (ID_W+1)'(1);
      if (nxtPtr >= NumReqW) nxtPtr = '0;
      rrPtr_d = nxtPtr[ID_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rrPtr_q <= '0;
      rspId_q <= '0;
      opA_q   <= '0;
      opB_q   <= '0;
    end else begin
      state_q <= state_d;
      rrPtr_q <= rrPtr_d;
      rspId_q <= rspId_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
    end
  end

  assign req_ready_o = grantOh;
  assign rsp_valid_o = (state_q == FULL);
  assign rsp_prod_o  = vedicProd;
  assign rsp_id_o    = rspId_q;

`ifdef MUL_SELFCHECK_EN
  logic        chkErr_q;
  logic [15:0] refProd;

  assign refProd = {8'h00, opA_q} * {8'h00, opB_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chkErr_q <= 1'b0;
    end else if ((state_q == FULL) && (vedicProd != refProd)) begin
      chkErr_q <= 1'b1;
    end
  end

  assign chk_err_o = chkErr_q;
`else
  assign chk_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// Bench for vedic_mul_arbiter: round-robin reference model plus product scoreboard,
// vector table for single requests and hand-written backpressure/reset sequences.

module tb_vedic_mul_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   reqValid;
  logic [8*N-1:0] reqA;
  logic [8*N-1:0] reqB;
  logic [N-1:0]   reqReady;
  logic           rspValid;
  logic [15:0]    rspProd;
  logic [IDW-1:0] rspId;
  logic           rspReady;
  logic           chkErr;

  typedef struct {
    logic [IDW-1:0] id;
    logic [15:0]    prod;
  } exp_t;

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;

  exp_t sbQ[$];
  int   passCount  = 0;
  int   checkCount = 0;
  int   mPtr       = 0;
  bit   mFull      = 1'b0;

  vedic_mul_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (reqValid),
    .req_a_i     (reqA),
    .req_b_i     (reqB),
    .req_ready_o (reqReady),
    .rsp_valid_o (rspValid),
    .rsp_prod_o  (rspProd),
    .rsp_id_o    (rspId),
    .rsp_ready_i (rspReady),
    .chk_err_o   (chkErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // One clock: drive inputs, check grant/response against the model, then cross the edge.
  task automatic applyStimulus(input logic [N-1:0] v, input logic rr, output int gOut);
    logic [N-1:0] expReady;
    int           g;
    exp_t         e;
    logic [7:0]   a, b;
    reqValid = v;
    rspReady = rr;
    #1;
    expReady = '0;
    g = -1;
    if (!mFull || rr) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(mPtr + k) % N]) g = (mPtr + k) % N;
      end
    end
    if (g >= 0) expReady[g] = 1'b1;
    checkOutput("req_ready", reqReady, expReady);
    checkOutput("rsp_valid", rspValid, mFull);
    if (mFull && rr) begin
      if (sbQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL scoreboard: response popped with no expected entry");
      end else begin
        e = sbQ.pop_front();
        checkOutput("rsp_prod", rspProd, e.prod);
        checkOutput("rsp_id", rspId, e.id);
      end
    end
    if (g >= 0) begin
      a      = reqA[8*g +: 8];
      b      = reqB[8*g +: 8];
      e.id   = IDW'(g);
      e.prod = {8'h00, a} * {8'h00, b};
      sbQ.push_back(e);
      mPtr  = (g + 1) % N;
      mFull = 1'b1;
    end else if (rr) begin
      mFull = 1'b0;
    end
    gOut = g;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst      = 1'b1;
    reqValid = '0;
    rspReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    mPtr  = 0;
    mFull = 1'b0;
    sbQ.delete();
  endtask

  function automatic logic [7:0] randOp();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'hFF;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int           g;
    int           accepts;
    int           cyc;
    vec_t         vecs[8];
    int           seq[5];
    logic [N-1:0] pending;

    vecs[0] = '{1, 8'd12,  8'd13,  16'd156};
    vecs[1] = '{0, 8'd255, 8'd255, 16'd65025};
    vecs[2] = '{2, 8'd0,   8'd77,  16'd0};
    vecs[3] = '{3, 8'd200, 8'd3,   16'd600};
    vecs[4] = '{1, 8'd1,   8'd255, 16'd255};
    vecs[5] = '{2, 8'd128, 8'd2,   16'd256};
    vecs[6] = '{0, 8'd0,   8'd0,   16'd0};
    vecs[7] = '{3, 8'd255, 8'd1,   16'd255};
    seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 3; seq[4] = 0;

    // Reset with every requester asking: nothing may be granted.
    rst      = 1'b1;
    reqValid = '1;
    reqA     = '0;
    reqB     = '0;
    rspReady = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("rst_req_ready", reqReady, 0);
    checkOutput("rst_rsp_valid", rspValid, 0);
    checkOutput("rst_rsp_prod", rspProd, 0);
    checkOutput("rst_rsp_id", rspId, 0);
    checkOutput("rst_chk_err", chkErr, 0);
    @(negedge clk);
    rst      = 1'b0;
    rspReady = 1'b1;
    #1;
    checkOutput("first_grant", reqReady, 1);
    applyStimulus(4'hF, 1'b1, g);
    applyStimulus(4'h0, 1'b1, g);

    for (int i = 0; i < 8; i++) begin
      reqA[8*vecs[i].id +: 8] = vecs[i].a;
      reqB[8*vecs[i].id +: 8] = vecs[i].b;
      applyStimulus(4'b0001 << vecs[i].id, 1'b1, g);
      checkOutput("vec_valid", rspValid, 1);
      checkOutput("vec_prod", rspProd, vecs[i].prod);
      checkOutput("vec_id", rspId, vecs[i].id);
      applyStimulus(4'h0, 1'b1, g);
    end

    // All four requesting: grants rotate 0,1,2,3,0 at one response per cycle.
    doReset();
    for (int i = 0; i < N; i++) begin
      reqA[8*i +: 8] = 8'(i * 17 + 3);
      reqB[8*i +: 8] = 8'(i * 29 + 5);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'hF, 1'b1, g);
      checkOutput("rr_valid", rspValid, 1);
      checkOutput("rr_id", rspId, seq[i]);
    end
    applyStimulus(4'h0, 1'b1, g);

    // Backpressure: 255*255 held for five stalled cycles, then pop with same-cycle regrant.
    reqA[7:0] = 8'd255;
    reqB[7:0] = 8'd255;
    applyStimulus(4'b0001, 1'b0, g);
    reqA[23:16] = 8'd3;
    reqB[23:16] = 8'd5;
    repeat (5) begin
      applyStimulus(4'b0101, 1'b0, g);
      checkOutput("bp_prod", rspProd, 65025);
      checkOutput("bp_ready", reqReady, 0);
    end
    applyStimulus(4'b0101, 1'b1, g);
    checkOutput("bp_next_id", rspId, 2);
    checkOutput("bp_next_prod", rspProd, 15);
    applyStimulus(4'h0, 1'b1, g);

    // Reset while 7*9 is buffered: it must vanish immediately and never reappear.
    reqA[31:24] = 8'd7;
    reqB[31:24] = 8'd9;
    applyStimulus(4'b1000, 1'b1, g);
    checkOutput("t5_pending_prod", rspProd, 63);
    reqValid = '0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_valid", rspValid, 0);
    checkOutput("t5_rst_prod", rspProd, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    mPtr  = 0;
    mFull = 1'b0;
    sbQ.delete();
    repeat (4) applyStimulus(4'h0, 1'b1, g);

    // Random sweep: requesters hold operands until granted, consumer stalls at random.
    pending = '0;
    accepts = 0;
    cyc     = 0;
    while (accepts < 1000 && cyc < 5000) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && ($urandom_range(0, 1) == 1)) begin
          pending[i]     = 1'b1;
          reqA[8*i +: 8] = randOp();
          reqB[8*i +: 8] = randOp();
        end
      end
      applyStimulus(pending, ($urandom_range(0, 3) != 0), g);
      if (g >= 0) begin
        pending[g] = 1'b0;
        accepts++;
      end
      cyc++;
    end
    checkOutput("sweep_accepts", accepts, 1000);
    repeat (3) applyStimulus(4'h0, 1'b1, g);
    checkOutput("sb_empty", sbQ.size(), 0);
    checkOutput("chk_err", chkErr, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
